// File: rtl/cache_bus_responder_pkg.sv
// Shared types and bus-encoding constants for the cache bus line-burst responder.
package cache_bus_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } statetype;

    localparam logic [1:0] BUSRW_READ  = 2'b10;
    localparam logic [1:0] BUSRW_WRITE = 2'b01;

endpackage

// File: rtl/cache_bus_ram.sv
// Single-port beat-wide backing RAM with registered read; contents are never reset.
module cache_bus_ram #(
    parameter int BEATLEN    = 64,
    parameter int MEMADRBITS = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MEMADRBITS-1:0] adr,
    input  logic [BEATLEN-1:0]    wd,
    output logic [BEATLEN-1:0]    rd
);

    logic [BEATLEN-1:0] mem [2**MEMADRBITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[adr] <= wd;
        end
        rd <= mem[adr];
    end

endmodule

// File: rtl/cache_bus_responder.sv
// Line-burst responder: services cache fetch/writeback bursts against a local RAM,
// assembling fetched lines into FetchBuffer and stepping BeatCount through writebacks.
module cache_bus_responder
    import cache_bus_responder_pkg::*;
#(
    parameter int PA_BITS    = 34,
    parameter int LINELEN    = 256,
    parameter int BEATLEN    = 64,
    parameter int LOGBWPL    = 2,
    parameter int MEMADRBITS = 12,
    parameter int LATENCY    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [BEATLEN-1:0] CacheBusWriteData,
    output logic               CacheBusAck,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic               SelBusBeat,
    output logic [LINELEN-1:0] FetchBuffer
);

    localparam int BEATSPERLINE = LINELEN / BEATLEN;
    localparam int ADRLO        = $clog2(LINELEN / 8);
    localparam int ADRHI        = MEMADRBITS + $clog2(BEATLEN / 8) - 1;
    localparam int LINEBITS     = MEMADRBITS - LOGBWPL;
    localparam int LATW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [LOGBWPL-1:0] LASTBEAT = LOGBWPL'(BEATSPERLINE - 1);
    localparam logic [LOGBWPL-1:0] PREBEAT  = LOGBWPL'(BEATSPERLINE - 2);

    statetype              stateReg, stateNext;
    logic [LINEBITS-1:0]   lineIdxReg;
    logic                  dirWriteReg;
    logic [LATW-1:0]       latCntReg;
    logic [LOGBWPL-1:0]    beatCountReg, beatCountNext;
    logic                  ackReg, ackNext;
    logic                  selReg, selNext;
    logic                  inBurst, lastBeat, request;

    logic                  ramWe;
    logic [LOGBWPL-1:0]    ramBeat;
    logic [MEMADRBITS-1:0] ramAdr;
    logic [BEATLEN-1:0]    ramRdData;
    logic [BEATLEN-1:0]    fetchSliceReg [BEATSPERLINE];

    logic                  unusedAdr;
    assign unusedAdr = ^{CacheBusAdr[PA_BITS-1:ADRHI+1], CacheBusAdr[ADRLO-1:0]};

    assign request  = (CacheBusRW != 2'b00);
    assign inBurst  = (stateReg == READ) || (stateReg == WRITE);
    assign lastBeat = inBurst && (beatCountReg == LASTBEAT);

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            lineIdxReg   <= '0;
            dirWriteReg  <= 1'b0;
            latCntReg    <= '0;
            beatCountReg <= '0;
            ackReg       <= 1'b0;
            selReg       <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            beatCountReg <= beatCountNext;
            ackReg       <= ackNext;
            selReg       <= selNext;
            if (stateReg == IDLE && request) begin
                // Upper address bits beyond the RAM simply alias (modulo depth).
                lineIdxReg  <= CacheBusAdr[ADRHI:ADRLO];
                dirWriteReg <= |(CacheBusRW & BUSRW_WRITE);
                latCntReg   <= LATW'(LATENCY - 1);
            end else if (stateReg == WAIT && latCntReg != '0) begin
                latCntReg <= latCntReg - LATW'(1);
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE:        if (request) stateNext = WAIT;
            WAIT:        if (latCntReg == '0) stateNext = dirWriteReg ? WRITE : READ;
            READ, WRITE: if (lastBeat) stateNext = IDLE;
            default:     stateNext = IDLE;
        endcase
    end

    // Next values for the registered outputs; ack is raised one beat early so it
    // is visible during the final beat itself.
    always_comb begin
        beatCountNext = '0;
        ackNext       = 1'b0;
        selNext       = 1'b0;
        unique case (stateReg)
            IDLE: begin
                beatCountNext = '0;
            end
            WAIT: begin
                selNext = (latCntReg == '0) && dirWriteReg;
            end
            READ, WRITE: begin
                if (!lastBeat) begin
                    beatCountNext = beatCountReg + LOGBWPL'(1);
                    ackNext       = (beatCountReg == PREBEAT);
                    selNext       = selReg;
                end
            end
            default: begin
                beatCountNext = '0;
            end
        endcase
    end

    // Reads run one beat ahead so RAM latency hides behind the beat sequence.
    assign ramBeat = (stateReg == READ) ? beatCountReg + LOGBWPL'(1) : beatCountReg;
    assign ramAdr  = {lineIdxReg, ramBeat};
    assign ramWe   = (stateReg == WRITE) && !reset;

    cache_bus_ram #(
        .BEATLEN    (BEATLEN),
        .MEMADRBITS (MEMADRBITS)
    ) ram (
        .clk (clk),
        .we  (ramWe),
        .adr (ramAdr),
        .wd  (CacheBusWriteData),
        .rd  (ramRdData)
    );

    generate
        for (genvar gi = 0; gi < BEATSPERLINE; gi++) begin : g_fetch
            always_ff @(posedge clk) begin
                if (reset) begin
                    fetchSliceReg[gi] <= '0;
                end else if (stateReg == READ && beatCountReg == LOGBWPL'(gi)) begin
                    fetchSliceReg[gi] <= ramRdData;
                end
            end
            assign FetchBuffer[gi*BEATLEN +: BEATLEN] = fetchSliceReg[gi];
        end
    endgenerate

    assign CacheBusAck = ackReg;
    assign BeatCount   = beatCountReg;
    assign SelBusBeat  = selReg;

    // Both request bits set is a cache bug; writeback still wins.
    assert property (@(posedge clk) disable iff (reset)
        (stateReg == IDLE) |-> (CacheBusRW != 2'b11))
        else $error("cache_bus_responder: CacheBusRW=2'b11 is illegal");

endmodule

// File: tb/tb_cache_bus_responder.sv
// Randomized and directed bursts checked against a line-level memory and timing model.
module tb_cache_bus_responder;
    import cache_bus_responder_pkg::*;

    localparam int LAT   = 2;
    localparam int BPL   = 4;
    localparam int LINES = 1024;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   CacheBusRW;
    logic [33:0]  CacheBusAdr;
    logic [63:0]  CacheBusWriteData;
    logic         CacheBusAck;
    logic [1:0]   BeatCount;
    logic         SelBusBeat;
    logic [255:0] FetchBuffer;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [63:0]  model [LINES*BPL];
    bit           known [LINES];
    bit           pending = 1'b0;
    logic [255:0] pendingLine;

    cache_bus_responder #(
        .PA_BITS(34), .LINELEN(256), .BEATLEN(64),
        .LOGBWPL(2), .MEMADRBITS(12), .LATENCY(LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .CacheBusRW        (CacheBusRW),
        .CacheBusAdr       (CacheBusAdr),
        .CacheBusWriteData (CacheBusWriteData),
        .CacheBusAck       (CacheBusAck),
        .BeatCount         (BeatCount),
        .SelBusBeat        (SelBusBeat),
        .FetchBuffer       (FetchBuffer)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lineOf(input logic [33:0] a);
        return int'((a / 34'd32) % 34'(LINES));
    endfunction

    function automatic logic [255:0] randLine();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    task automatic flushPending();
        if (pending) begin
            checkVal("fetchLine", FetchBuffer, pendingLine);
            pending = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            flushPending();
            CacheBusRW = 2'b00;
            checkVal("idleCtl", 256'({CacheBusAck, SelBusBeat, BeatCount}), 256'(0));
        end
    endtask

    // One request: cycle 0 is the acceptance cycle, beats at LAT+1..LAT+BPL.
    task automatic doBurst(input bit isWrite, input logic [33:0] adr, input logic [255:0] wline,
                           input int dropAt, input int resetAt);
        int           line;
        int           k;
        bit           inBeat;
        logic [255:0] expLine;
        logic [3:0]   expCtl;
        line = lineOf(adr);
        for (int j = 0; j < BPL; j++) expLine[64*j +: 64] = model[line*BPL + j];
        for (int c = 0; c <= LAT + BPL; c++) begin
            @(posedge clk); #1;
            flushPending();
            inBeat = (c >= LAT + 1);
            k      = inBeat ? c - LAT - 1 : 0;
            expCtl = {(c == LAT + BPL), (isWrite && inBeat), (inBeat ? 2'(k) : 2'd0)};
            checkVal("burstCtl", 256'({CacheBusAck, SelBusBeat, BeatCount}), 256'(expCtl));
            CacheBusAdr = adr;
            if (inBeat && dropAt >= 0 && k >= dropAt) CacheBusRW = 2'b00;
            else CacheBusRW = isWrite ? BUSRW_WRITE : BUSRW_READ;
            reset = inBeat && (k == resetAt);
            CacheBusWriteData = (isWrite && inBeat) ? wline[64*k +: 64] : {$urandom, $urandom};
            if (isWrite && inBeat && !reset) model[line*BPL + k] = wline[64*k +: 64];
            if (reset) begin
                @(posedge clk); #1;
                reset      = 1'b0;
                CacheBusRW = 2'b00;
                checkVal("rstCtl", 256'({CacheBusAck, SelBusBeat, BeatCount}), 256'(0));
                checkVal("rstFetch", FetchBuffer, 256'(0));
                $display("txn %0d %s line=%0d reset at beat %0d", txn, isWrite ? "WB" : "FETCH", line, resetAt);
                txn++;
                return;
            end
        end
        if (isWrite) begin
            known[line] = 1'b1;
        end else begin
            pending     = 1'b1;
            pendingLine = expLine;
        end
        $display("txn %0d %s adr=%h line=%0d drop=%0d", txn, isWrite ? "WB" : "FETCH", adr, line, dropAt);
        txn++;
    endtask

    initial begin
        logic [255:0] wl;
        logic [33:0]  adr;
        int           line, hi, off, drop, gap;
        bit           wr;

        reset = 1'b1;
        CacheBusRW = 2'b00;
        CacheBusAdr = '0;
        CacheBusWriteData = '0;
        for (int i = 0; i < LINES; i++) known[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rstCtl", 256'({CacheBusAck, SelBusBeat, BeatCount}), 256'(0));
        checkVal("rstFetch", FetchBuffer, 256'(0));
        reset = 1'b0;
        idle(20);

        doBurst(1'b1, 34'h0, randLine(), -1, -1);
        for (int j = 0; j < BPL; j++) wl[64*j +: 64] = 64'(8'hA0 + j);
        doBurst(1'b1, 34'h080000040, wl, -1, -1);
        doBurst(1'b0, 34'h080000040, '0, -1, -1);
        idle(1);
        checkVal("lineA", FetchBuffer, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

        // Writeback immediately followed by a fetch of a different line.
        doBurst(1'b1, 34'(9 * 32), randLine(), -1, -1);
        doBurst(1'b0, 34'h0, '0, -1, -1);

        doBurst(1'b0, 34'h080000040, '0, 1, -1);
        idle(1);

        for (int j = 0; j < BPL; j++) wl[64*j +: 64] = 64'(8'hB0 + j);
        doBurst(1'b1, 34'h080000040, wl, -1, 2);
        idle(2);
        doBurst(1'b0, 34'h080000040, '0, -1, -1);
        idle(1);
        checkVal("partialWb", FetchBuffer, {64'hA3, 64'hA2, 64'hB1, 64'hB0});

        doBurst(1'b0, 34'(LINES * 32), '0, -1, -1);
        idle(1);

        for (int i = 0; i < 24; i++) begin
            line = int'($urandom_range(0, 15));
            hi   = int'($urandom_range(0, 15));
            off  = int'($urandom_range(0, 31));
            adr  = 34'(hi) * 34'(LINES * 32) + 34'(line * 32 + off);
            wr   = !known[line] || ($urandom_range(0, 1) == 1);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            doBurst(wr, adr, randLine(), drop, -1);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
